// File: rtl/bregisters_sb.sv
// Register bank with two registered read ports, write-to-read bypass and a
// per-register busy scoreboard that the control FSM reserves and writes release.

module bregisters_sb_rdport #(
  parameter int Size    = 8,
  parameter int AW      = 2,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             re,
  input  logic [AW-1:0]                    a,
  input  logic                             we_eff,
  input  logic [AW-1:0]                    wa,
  input  logic [Size-1:0]                  wd,
  input  logic [(1<<AW)-1:0][Size-1:0]     regs,
  input  logic [(1<<AW)-1:0]               busy,
  output logic [Size-1:0]                  rd,
  output logic                             v
);
  logic [Size-1:0] rd_q, rd_d;
  logic            v_q, v_d;

  // Bypass beats busy: the write that releases the register also supplies the data.
  always_comb begin
    rd_d = rd_q;
    v_d  = 1'b0;
    if (re) begin
      if (we_eff && (wa == a)) begin
        rd_d = wd;
        v_d  = 1'b1;
      end else if (!busy[a]) begin
        rd_d = (ZERO_R0 && (a == '0)) ? '0 : regs[a];
        v_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_q <= '0;
      v_q  <= 1'b0;
    end else begin
      rd_q <= rd_d;
      v_q  <= v_d;
    end
  end

  assign rd = rd_q;
  assign v  = v_q;
endmodule

module bregisters_sb #(
  parameter int Size    = 8,
  parameter int AW      = 2,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [Size-1:0]       wd,
  input  logic                  re1,
  input  logic [AW-1:0]         a1,
  output logic [Size-1:0]       rd1,
  output logic                  v1,
  input  logic                  re2,
  input  logic [AW-1:0]         a2,
  output logic [Size-1:0]       rd2,
  output logic                  v2,
  input  logic                  rsv,
  input  logic [AW-1:0]         ra,
  output logic                  rsv_ok,
  output logic [(1<<AW)-1:0]    busy
);
  localparam int NREG = 1 << AW;

  logic [NREG-1:0][Size-1:0] regs_q, regs_d;
  logic [NREG-1:0]           busy_q, busy_d;
  logic                      rsv_ok_q, rsv_ok_d;
  logic                      we_eff, rsv_acc;

  // Reserve is applied after the write release so a same-address reserve wins;
  // acceptance looks only at pre-edge busy.
  always_comb begin
    we_eff  = we && !(ZERO_R0 && (wa == '0));
    rsv_acc = rsv && !busy_q[ra] && !(ZERO_R0 && (ra == '0));
    regs_d  = regs_q;
    busy_d  = busy_q;
    if (we_eff) begin
      regs_d[wa] = wd;
      busy_d[wa] = 1'b0;
    end
    if (rsv_acc) busy_d[ra] = 1'b1;
    rsv_ok_d = rsv_acc;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      regs_q   <= '0;
      busy_q   <= '0;
      rsv_ok_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      rsv_ok_q <= rsv_ok_d;
    end
  end

  logic [1:0]                re_v, v_v;
  logic [1:0][AW-1:0]        a_v;
  logic [1:0][Size-1:0]      rd_v;

  assign re_v = {re2, re1};
  assign a_v  = {a2, a1};

  for (genvar gp = 0; gp < 2; gp++) begin : g_rd
    bregisters_sb_rdport #(.Size(Size), .AW(AW), .ZERO_R0(ZERO_R0)) u_rd (
      .clk    (clk),
      .rstn   (rstn),
      .re     (re_v[gp]),
      .a      (a_v[gp]),
      .we_eff (we_eff),
      .wa     (wa),
      .wd     (wd),
      .regs   (regs_q),
      .busy   (busy_q),
      .rd     (rd_v[gp]),
      .v      (v_v[gp])
    );
  end

  assign rd1    = rd_v[0];
  assign v1     = v_v[0];
  assign rd2    = rd_v[1];
  assign v2     = v_v[1];
  assign rsv_ok = rsv_ok_q;
  assign busy   = busy_q;
endmodule
